// File: rtl/sel_debounce_if.sv
// sel_debounce_if -- signal bundle between the select debouncer and its user.
//   key_n       raw active-low pushbutton (asynchronous, bouncing)
//   sw_sel      raw slide-switch level (asynchronous)
//   mode        0: s toggles per debounced press, 1: s follows the switch
//   s           registered mux select
//   press_pulse one-cycle strobe per accepted press
//   busy        debounce window in progress
// master drives the raw inputs and mode; slave is the debouncer.
interface sel_debounce_if;
    logic key_n;
    logic sw_sel;
    logic mode;
    logic s;
    logic press_pulse;
    logic busy;

    modport master (output key_n, sw_sel, mode, input s, press_pulse, busy);
    modport slave  (input key_n, sw_sel, mode, output s, press_pulse, busy);
endinterface

// File: rtl/sel_debounce.sv
// sel_debounce -- debounced pushbutton / slide-switch source for a 2:1 mux select.
//   Clock   system clock, rising edge
//   Resetn  asynchronous active-low reset
//   bus     sel_debounce_if.slave (key_n, sw_sel, mode in; s, press_pulse, busy out)
// The key is synchronized, then a four-state FSM requires DEBOUNCE_CYCLES stable
// cycles (after the first sample that changed) before accepting a press or release.
module sel_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic           Clock,
    input  logic           Resetn,
    sel_debounce_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             key_m, key_s;
    logic             sw_m, sw_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_d, pulse_q;
    logic             busy_q;
    logic             s_q;

    // Two-flop synchronizers; the key idles released (1), the switch idles at 0.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            key_m <= 1'b1;
            key_s <= 1'b1;
            sw_m  <= 1'b0;
            sw_s  <= 1'b0;
        end else begin
            key_m <= bus.key_n;
            key_s <= key_m;
            sw_m  <= bus.sw_sel;
            sw_s  <= sw_m;
        end
    end

    // Next-state logic. The counter only advances below CNT_MAX, so it never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!key_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (key_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (key_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!key_s) begin
                    // Bounce during release: back to held, no new pulse.
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            s_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            // Registered from the current state so the busy window ends on the
            // same cycle as the press strobe.
            busy_q  <= (state_q == PRESS_WAIT) || (state_q == RELEASE_WAIT);
            // mode=1 wins over a coincident pulse; leaving mode=1 just holds s.
            if (bus.mode)
                s_q <= sw_s;
            else
                s_q <= s_q ^ pulse_q;
        end
    end

    assign bus.s           = s_q;
    assign bus.press_pulse = pulse_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_sel_debounce.sv
// tb_sel_debounce -- directed + randomized bench for sel_debounce (DEBOUNCE_CYCLES=4).
// The reference model tracks the accepted key level and the length of the current
// run of synchronized samples that disagree with it; a run of D+1 flips acceptance.
module tb_sel_debounce;
    localparam int D = 4;

    logic Clock  = 1'b0;
    logic Resetn = 1'b0;

    sel_debounce_if bus();

    sel_debounce #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    always #5 Clock = ~Clock;

    int tests  = 0;
    int fails  = 0;
    int npulse = 0;

    // reference model state (values visible after the most recent edge)
    logic m_k1, m_k2, m_w1, m_w2;
    logic m_acc;
    int   m_run;
    logic m_s, m_pulse, m_busy;

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_k1 = 1'b1; m_k2 = 1'b1;
        m_w1 = 1'b0; m_w2 = 1'b0;
        m_acc = 1'b0; m_run = 0;
        m_s = 1'b0; m_pulse = 1'b0; m_busy = 1'b0;
    endtask

    task automatic model_edge();
        logic ks, ws, ns;
        int   old_run;
        ks      = m_k2;
        ws      = m_w2;
        old_run = m_run;
        ns      = bus.mode ? ws : (m_s ^ m_pulse);
        m_pulse = 1'b0;
        if (ks == ~m_acc) m_run = 0;
        else              m_run++;
        if (m_run == D + 1) begin
            m_acc   = ~m_acc;
            m_run   = 0;
            m_pulse = m_acc;
        end
        m_busy = (old_run > 0);
        m_s    = ns;
        m_k2 = m_k1; m_k1 = bus.key_n;
        m_w2 = m_w1; m_w1 = bus.sw_sel;
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic step();
        @(posedge Clock);
        model_edge();
        @(negedge Clock);
        chk("press_pulse", bus.press_pulse, m_pulse);
        chk("busy", bus.busy, m_busy);
        chk("s", bus.s, m_s);
        if (bus.press_pulse === 1'b1) npulse++;
    endtask

    // Called at a falling edge; outputs must clear without waiting for a clock.
    task automatic do_reset();
        Resetn = 1'b0;
        #1;
        chk("rst_pulse", bus.press_pulse, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_s", bus.s, 1'b0);
        model_reset();
        @(posedge Clock);
        @(negedge Clock);
        Resetn = 1'b1;
    endtask

    initial begin
        int krun;
        bus.key_n  = 1'b1;
        bus.sw_sel = 1'b0;
        bus.mode   = 1'b0;
        model_reset();
        @(negedge Clock);
        do_reset();
        repeat (4) step();

        // clean press: pulse only after edge 7, busy after edges 4..7, s=1 from edge 8
        bus.key_n = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk("clean_pulse", bus.press_pulse, logic'(e == 7));
            chk("clean_busy", bus.busy, logic'(e >= 4 && e <= 7));
            chk("clean_s", bus.s, logic'(e >= 8));
        end
        bus.key_n = 1'b1;
        repeat (12) step();

        // press bounce: low 3, high 2, low held -> exactly one pulse
        npulse = 0;
        bus.key_n = 1'b0; repeat (3) step();
        bus.key_n = 1'b1; repeat (2) step();
        bus.key_n = 1'b0; repeat (12) step();
        chki("bounce_pulses", npulse, 1);
        chk("bounce_s", bus.s, 1'b0);

        // release bounce while held: no extra pulse, ends back in held state
        npulse = 0;
        for (int i = 0; i < 5; i++) begin
            bus.key_n = (i % 2 == 0) ? 1'b1 : 1'b0;
            repeat (2) step();
        end
        bus.key_n = 1'b0;
        repeat (8) step();
        chki("relbounce_pulses", npulse, 0);
        chk("relbounce_busy", bus.busy, 1'b0);
        chk("relbounce_s", bus.s, 1'b0);
        bus.key_n = 1'b1;
        repeat (12) step();

        // two separate presses: s 0 -> 1 -> 0
        npulse = 0;
        bus.key_n = 1'b0; repeat (10) step();
        chk("two_s1", bus.s, 1'b1);
        bus.key_n = 1'b1; repeat (10) step();
        bus.key_n = 1'b0; repeat (10) step();
        chk("two_s2", bus.s, 1'b0);
        bus.key_n = 1'b1; repeat (10) step();
        chki("two_pulses", npulse, 2);

        // switch mode: s follows sw_sel three edges after the change
        bus.mode = 1'b1;
        repeat (4) step();
        bus.sw_sel = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            step();
            chk("sw_latency", bus.s, logic'(e >= 3));
        end
        bus.mode = 1'b0;
        repeat (6) step();
        chk("mode_hold", bus.s, 1'b1);
        bus.key_n = 1'b0; repeat (10) step();
        chk("mode_press", bus.s, 1'b0);
        bus.key_n = 1'b1; repeat (10) step();

        // press accepted in the same cycle mode goes to 1: s takes sw_s (0), no toggle
        bus.sw_sel = 1'b0;
        repeat (4) step();
        bus.key_n = 1'b0;
        repeat (7) step();
        chk("coinc_pulse", bus.press_pulse, 1'b1);
        bus.mode = 1'b1;
        step();
        chk("coinc_s", bus.s, 1'b0);
        bus.key_n = 1'b1; repeat (10) step();
        bus.mode = 1'b0;
        repeat (2) step();

        // reset during PRESS_WAIT (counter=2), then key still low -> one press
        npulse = 0;
        bus.key_n = 1'b0;
        repeat (5) step();
        chk("pw_busy", bus.busy, 1'b1);
        do_reset();
        chki("rst_nopulse", npulse, 0);
        for (int e = 1; e <= 8; e++) begin
            step();
            chk("post_rst_pulse", bus.press_pulse, logic'(e == 7));
        end
        // key held indefinitely: still one pulse
        repeat (40) step();
        chki("hold_pulses", npulse, 1);
        bus.key_n = 1'b1;
        repeat (12) step();

        // randomized: bouncing key runs, switch and mode changes, occasional reset
        krun = 0;
        for (int c = 0; c < 3000; c++) begin
            if (krun == 0) begin
                bus.key_n = ~bus.key_n;
                krun = int'($urandom_range(1, 2 * D + 4));
            end
            krun--;
            if ($urandom_range(0, 19) == 0) bus.sw_sel = ~bus.sw_sel;
            if ($urandom_range(0, 49) == 0) bus.mode = ~bus.mode;
            if ($urandom_range(0, 399) == 0) do_reset();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sel_debounce.md
SEL_DEBOUNCE -- requirements
Module: sel_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, SHALL set the number of consecutive stable clock cycles required to accept a key transition (10 ms at 50 MHz); legal range 2..2^20-1.
REQ-002 Parameter CNT_W, default 20, SHALL set the stability counter width; the counter SHALL hold DEBOUNCE_CYCLES-1.
REQ-003 Clock  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-004 Resetn  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 key_n  input  1  SHALL be the raw active-low pushbutton, asynchronous to Clock and bouncing.
REQ-006 sw_sel  input  1  SHALL be the raw slide-switch select level, asynchronous to Clock.
REQ-007 mode  input  1  SHALL select the source of s: 0 = toggle on each debounced press, 1 = follow sw_sel; synchronous to Clock.
REQ-008 s  output  1  SHALL be the registered select line driven into the downstream 2-to-1 mux select input.
REQ-009 press_pulse  output  1  SHALL be a registered one-cycle strobe marking each accepted press.
REQ-010 busy  output  1  SHALL be high while the FSM is in PRESS_WAIT or RELEASE_WAIT.

Function
REQ-011 key_n and sw_sel SHALL each pass through a two-flop synchronizer before any other use; key_s and sw_s denote the synchronizer outputs.
REQ-012 The FSM SHALL have exactly four states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-013 IDLE: key_s==0 -> PRESS_WAIT with the counter cleared to 0; otherwise remain in IDLE.
REQ-014 PRESS_WAIT: key_s==1 -> IDLE with the counter cleared; key_s==0 with counter==DEBOUNCE_CYCLES-1 -> PRESSED; otherwise increment the counter.
REQ-015 The PRESS_WAIT -> PRESSED transition SHALL assert press_pulse for exactly the following cycle.
REQ-016 PRESSED: key_s==1 -> RELEASE_WAIT with the counter cleared; otherwise remain in PRESSED with no further pulse.
REQ-017 RELEASE_WAIT: key_s==0 -> PRESSED with no pulse; key_s==1 with counter==DEBOUNCE_CYCLES-1 -> IDLE; otherwise increment the counter.
REQ-018 Latency: a clean press (raw key_n low and stable) SHALL raise press_pulse exactly DEBOUNCE_CYCLES+3 cycles after the first rising edge that samples key_n low.
REQ-019 mode==0: s SHALL invert on the cycle press_pulse is high and hold otherwise.
REQ-020 mode==1: s SHALL equal sw_s registered one cycle, i.e. 3 cycles after the raw change; press_pulse and busy keep operating and SHALL NOT affect s.
REQ-021 On a mode change from 1 to 0, s SHALL hold its current value, with no glitch or toggle.
REQ-022 A press accepted in the same cycle as a mode change from 0 to 1 SHALL be ignored for s; s SHALL take sw_s.
REQ-023 The counter SHALL never wrap; a bounce of any length shorter than DEBOUNCE_CYCLES SHALL produce no pulse.
REQ-024 A key held indefinitely SHALL produce exactly one pulse.

Reset
REQ-025 Resetn low SHALL immediately force: state IDLE, counter 0, s=0, press_pulse=0, busy=0, key synchronizer flops=1, sw synchronizer flops=0.
REQ-026 Reset asserted mid-operation in any state SHALL abandon the press without emitting a pulse; after release, operation SHALL resume from IDLE.
REQ-027 After Resetn deassertion with key_n held low, one debounced press SHALL be accepted (DEBOUNCE_CYCLES+3 cycles later).

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Clean press: mode=0, key_n low at cycle 0 and held -> press_pulse high only at cycle 7, s 0->1 at cycle 8, busy high cycles 4-7.
REQ-029 Bounce: key_n low 3 cycles, high 2, low held -> no pulse until 4 stable synchronized low cycles complete; exactly one pulse; s toggles once.
REQ-030 Release bounce: while PRESSED, key_n toggles high/low every 2 cycles for 10 cycles, then stays low -> zero additional pulses, FSM returns to PRESSED.
REQ-031 Two separate presses, each released for at least 8 cycles -> two pulses; s goes 0->1->0.
REQ-032 mode=1, sw_sel 0->1 at cycle 0 -> s=1 at cycle 3; switch mode to 0 -> s stays 1; next press -> s=0.
REQ-033 Resetn pulsed low during PRESS_WAIT at counter=2 -> s=0, press_pulse=0, busy=0 immediately; no pulse emitted.
